// File: rtl/demux4_deser.sv
// Serial-to-parallel capture: a 2-bit lane counter steers each valid bit into its lane.
// Completed nibbles go out through a valid/ready handshake, with a sticky overrun flag.
module demux4_deser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  input  logic       word_ready,
  output logic [3:0] word,
  output logic       word_valid,
  output logic [1:0] lane,
  output logic       overrun
);

  logic [1:0] cnt;
  logic [2:0] lbuf;
  logic       step, complete, xfer;

  assign lane     = cnt;
  assign step     = din_valid & ~sync;
  assign complete = step & (cnt == 2'd3);
  assign xfer     = word_valid & word_ready;

  // Lanes 0-2 hold partial bits; lane 3 goes straight into word.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam logic [1:0] LN = 2'(g);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   lbuf[g] <= 1'b0;
      else if (sync)                lbuf[g] <= 1'b0;
      else if (step && cnt == LN)   lbuf[g] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      word       <= 4'd0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sync)      cnt <= 2'd0;
      else if (step) cnt <= cnt + 2'd1;

      if (complete) word <= {din, lbuf};

      if (complete)  word_valid <= 1'b1;
      else if (xfer) word_valid <= 1'b0;

      // A completion that finds an unaccepted word drops the old one.
      if (sync)                                        overrun <= 1'b0;
      else if (complete && word_valid && !word_ready)  overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux4_deser.sv
// Directed bench for demux4_deser: hand-computed words, handshake, overrun, sync, async reset.
module tb_demux4_deser;

  logic       clk, rst_n, din, din_valid, sync, word_ready;
  logic [3:0] word;
  logic       word_valid, overrun;
  logic [1:0] lane;

  int n_run = 0;
  int n_fail = 0;

  demux4_deser dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .word_ready(word_ready), .word(word), .word_valid(word_valid), .lane(lane),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic tick(input logic dv, input logic d, input logic sy, input logic rdy);
    din_valid  = dv;
    din        = d;
    sync       = sy;
    word_ready = rdy;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    sync       = 1'b0;
    word_ready = 1'b0;
  endtask

  // Send n valid bits (LSB first) back to back; ready held on the last one only.
  task automatic send(input logic [3:0] bits, input int n, input logic rdy_last);
    for (int i = 0; i < n; i++)
      tick(1'b1, bits[i], 1'b0, (i == n - 1) ? rdy_last : 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0; word_ready = 1'b0;
    #3;
    chk("rst_word", {4'd0, word}, 8'h0);
    chk("rst_valid", {7'd0, word_valid}, 8'h0);
    chk("rst_lane", {6'd0, lane}, 8'h0);
    chk("rst_ovr", {7'd0, overrun}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,1,1 -> D, lane walks 0..3 then wraps
    begin
      logic [3:0] b;
      b = 4'b1101;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_lane%0d", i), {6'd0, lane}, 8'(i));
        tick(1'b1, b[i], 1'b0, 1'b0);
      end
    end
    chk("t1_lane_wrap", {6'd0, lane}, 8'h0);
    chk("t1_word", {4'd0, word}, 8'hD);
    chk("t1_valid", {7'd0, word_valid}, 8'h1);
    chk("t1_ovr", {7'd0, overrun}, 8'h0);

    // accept, then gapped bits 0,1,1,0 -> 6
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_valid_drop", {7'd0, word_valid}, 8'h0);
    chk("t2_word_hold", {4'd0, word}, 8'hD);
    tick(1'b1, 1'b0, 1'b0, 1'b0); tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0); tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_lane_gap", {6'd0, lane}, 8'h3);
    chk("t2_not_yet", {7'd0, word_valid}, 8'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_word", {4'd0, word}, 8'h6);
    chk("t2_valid", {7'd0, word_valid}, 8'h1);

    // D left pending, 0,0,0,1 overwrites it -> 8 with overrun
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'hD, 4, 1'b0);
    chk("t3_word_d", {4'd0, word}, 8'hD);
    send(4'h8, 4, 1'b0);
    chk("t3_word", {4'd0, word}, 8'h8);
    chk("t3_valid", {7'd0, word_valid}, 8'h1);
    chk("t3_ovr", {7'd0, overrun}, 8'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_sync_ovr", {7'd0, overrun}, 8'h0);
    chk("t3_sync_lane", {6'd0, lane}, 8'h0);
    chk("t3_sync_word", {4'd0, word}, 8'h8);
    chk("t3_sync_valid", {7'd0, word_valid}, 8'h1);

    // 3 pending, F completes with ready on the same edge
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'h3, 4, 1'b0);
    chk("t4_word3", {4'd0, word}, 8'h3);
    send(4'hF, 4, 1'b1);
    chk("t4_word", {4'd0, word}, 8'hF);
    chk("t4_valid", {7'd0, word_valid}, 8'h1);
    chk("t4_ovr", {7'd0, overrun}, 8'h0);

    // sync with a valid bit drops the bit and the partial word
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'h3, 2, 1'b0);
    chk("t5_lane2", {6'd0, lane}, 8'h2);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_sync_lane", {6'd0, lane}, 8'h0);
    chk("t5_no_word", {7'd0, word_valid}, 8'h0);
    send(4'hA, 4, 1'b0);
    chk("t5_word", {4'd0, word}, 8'hA);
    chk("t5_valid", {7'd0, word_valid}, 8'h1);

    // async reset mid-word with A still pending
    send(4'h7, 3, 1'b0);
    chk("t6_lane3", {6'd0, lane}, 8'h3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_word", {4'd0, word}, 8'h0);
    chk("t6_rst_valid", {7'd0, word_valid}, 8'h0);
    chk("t6_rst_lane", {6'd0, lane}, 8'h0);
    chk("t6_rst_ovr", {7'd0, overrun}, 8'h0);
    #1 rst_n = 1'b1;
    send(4'h3, 4, 1'b0);
    chk("t6_word", {4'd0, word}, 8'h3);
    chk("t6_valid", {7'd0, word_valid}, 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
